mm_bus_arbiter: RTL and testbench

MM_BUS_ARBITER -- requirements
Module: mm_bus_arbiter

---
 rtl/mm_bus_pkg.sv | 14 +
 rtl/mm_bus_arbiter_if.sv | 14 +
 rtl/mm_rr_arb2.sv | 18 +
 rtl/mm_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_mm_bus_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mm_bus_pkg.sv
// Shared types and constants for the two-requester memory-mapped bus arbiter.
package mm_bus_pkg;
    localparam int ADDR_W = 17;
    localparam logic [63:0] TIMEOUT_PAT = 64'hDEAD_BEEF_DEAD_BEEF;

    typedef enum logic [1:0] {IDLE, WR, RD_WAIT} arb_state_e;

    typedef struct packed {
        logic              wr;
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [63:0]       data;
    } mm_req_t;
endpackage

// File: rtl/mm_bus_arbiter_if.sv
// Requester-side handshake bundle; the requester is the master, the arbiter the slave.
interface mm_bus_arbiter_if;
    import mm_bus_pkg::*;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       wr_data;
    logic              ready;
    logic [63:0]       rd_data;
    logic              rd_data_v;

    modport master (output wr_en, rd_en, addr, wr_data, input ready, rd_data, rd_data_v);
    modport slave  (input wr_en, rd_en, addr, wr_data, output ready, rd_data, rd_data_v);
endinterface

// File: rtl/mm_rr_arb2.sv
// Two-way round-robin pick; the pointer remembers the last granted requester.
module mm_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_idx
);
    logic last;

    // On a tie the one not served last wins; otherwise the sole requester.
    always_comb gnt_idx = (&req) ? ~last : ~req[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               last <= 1'b1;
        else if (take && |req)    last <= gnt_idx;
    end
endmodule

// File: rtl/mm_bus_arbiter.sv
// Arbitrates two requesters onto one memory-mapped bus, one outstanding read at a time.
// Optional read timeout is enabled by defining MM_ARB_TIMEOUT_EN.
module mm_bus_arbiter
    import mm_bus_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    mm_bus_arbiter_if.slave   rq0,
    mm_bus_arbiter_if.slave   rq1,
    output logic              oMM_WR_EN,
    output logic              oMM_RD_EN,
    output logic [ADDR_W-1:0] oMM_ADDR,
    output logic [63:0]       oMM_WR_DATA,
    input  logic [63:0]       iMM_RD_DATA,
    input  logic              iMM_RD_DATA_V,
    output logic              timeout_err,
    input  logic              timeout_clr
);
    arb_state_e     state;
    mm_req_t [1:0]  req;
    mm_req_t        win;
    logic [1:0]     pend;
    logic           gnt_idx;
    logic           owner;
    logic [1:0]     ready_q;
    logic [1:0]     rdv_q;
    logic [63:0]    rd_data_q;
    logic           to_hit;

    assign req[0] = '{wr: rq0.wr_en, rd: rq0.rd_en, addr: rq0.addr, data: rq0.wr_data};
    assign req[1] = '{wr: rq1.wr_en, rd: rq1.rd_en, addr: rq1.addr, data: rq1.wr_data};
    assign pend   = {req[1].wr | req[1].rd, req[0].wr | req[0].rd};
    assign win    = gnt_idx ? req[1] : req[0];

    mm_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (pend),
        .take    (state == IDLE),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            ready_q     <= '0;
            rdv_q       <= '0;
            rd_data_q   <= '0;
            oMM_WR_EN   <= 1'b0;
            oMM_RD_EN   <= 1'b0;
            oMM_ADDR    <= '0;
            oMM_WR_DATA <= '0;
        end else begin
            ready_q   <= '0;
            rdv_q     <= '0;
            oMM_WR_EN <= 1'b0;
            oMM_RD_EN <= 1'b0;
            case (state)
                IDLE: if (|pend) begin
                    oMM_ADDR    <= win.addr;
                    oMM_WR_DATA <= win.data;
                    ready_q     <= gnt_idx ? 2'b10 : 2'b01;
                    // A request carrying both enables is treated as a write.
                    if (win.wr) begin
                        oMM_WR_EN <= 1'b1;
                        state     <= WR;
                    end else begin
                        oMM_RD_EN <= win.rd;
                        owner     <= gnt_idx;
                        state     <= RD_WAIT;
                    end
                end
                WR: state <= IDLE;
                RD_WAIT: begin
                    if (iMM_RD_DATA_V) begin
                        rd_data_q <= iMM_RD_DATA;
                        rdv_q     <= owner ? 2'b10 : 2'b01;
                        state     <= IDLE;
                    end else if (to_hit) begin
                        rd_data_q <= TIMEOUT_PAT;
                        rdv_q     <= owner ? 2'b10 : 2'b01;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MM_ARB_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       terr_q;

    // Counter is zero on RD_WAIT entry; the timeout lands on the TIMEOUT_CYC-th wait edge.
    assign to_hit = (state == RD_WAIT) && !iMM_RD_DATA_V && (to_cnt == 8'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 to_cnt <= '0;
        else if (state == RD_WAIT)  to_cnt <= to_cnt + 8'd1;
        else                        to_cnt <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           terr_q <= 1'b0;
        else if (to_hit)      terr_q <= 1'b1;
        else if (timeout_clr) terr_q <= 1'b0;
    end

    assign timeout_err = terr_q;
`else
    logic unused_clr;
    localparam int unused_to = TIMEOUT_CYC;
    assign unused_clr  = timeout_clr;
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign rq0.ready     = ready_q[0];
    assign rq1.ready     = ready_q[1];
    assign rq0.rd_data   = rd_data_q;
    assign rq1.rd_data   = rd_data_q;
    assign rq0.rd_data_v = rdv_q[0];
    assign rq1.rd_data_v = rdv_q[1];
endmodule

// File: tb/tb_mm_bus_arbiter.sv
// Bench for mm_bus_arbiter: directed cases plus randomized traffic against a transaction model.
module tb_mm_bus_arbiter;
    import mm_bus_pkg::*;
    localparam int TO = 8;
`ifdef MM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mm_bus_arbiter_if rq0_i ();
    mm_bus_arbiter_if rq1_i ();

    logic [1:0]        r_wr = '0, r_rd = '0;
    logic [1:0][16:0]  r_addr = '0;
    logic [1:0][63:0]  r_wd = '0;
    logic              mm_wr_en, mm_rd_en, mm_rv = 1'b0, terr, tclr = 1'b0;
    logic [16:0]       mm_addr;
    logic [63:0]       mm_wdata, mm_rdata = '0;

    assign rq0_i.wr_en = r_wr[0];  assign rq1_i.wr_en = r_wr[1];
    assign rq0_i.rd_en = r_rd[0];  assign rq1_i.rd_en = r_rd[1];
    assign rq0_i.addr = r_addr[0]; assign rq1_i.addr = r_addr[1];
    assign rq0_i.wr_data = r_wd[0]; assign rq1_i.wr_data = r_wd[1];

    wire [1:0]  o_ready = {rq1_i.ready, rq0_i.ready};
    wire [1:0]  o_rdv   = {rq1_i.rd_data_v, rq0_i.rd_data_v};
    wire [63:0] o_rd0   = rq0_i.rd_data;
    wire [63:0] o_rd1   = rq1_i.rd_data;

    mm_bus_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rq0(rq0_i), .rq1(rq1_i),
        .oMM_WR_EN(mm_wr_en), .oMM_RD_EN(mm_rd_en), .oMM_ADDR(mm_addr), .oMM_WR_DATA(mm_wdata),
        .iMM_RD_DATA(mm_rdata), .iMM_RD_DATA_V(mm_rv), .timeout_err(terr), .timeout_clr(tclr)
    );

    int n_cmp = 0, n_err = 0;
    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the bus, and what each output must show.
    logic [1:0]  e_ready = '0, e_rdv = '0;
    logic        e_wr = 0, e_rd = 0, e_terr = 0;
    logic [16:0] e_addr = '0;
    logic [63:0] e_wd = '0, e_rdata = '0;
    int rd_owner = -1, wr_tail = 0, waited = 0, last = 1;
    bit m_live = 0;

    always @(posedge clk) begin
        bit hit;
        bit [1:0] p;
        int w;
        m_live = 1;
        hit = 0;
        if (!rst_n) begin
            e_ready = '0; e_rdv = '0; e_wr = 0; e_rd = 0; e_terr = 0;
            e_addr = '0; e_wd = '0; e_rdata = '0;
            rd_owner = -1; wr_tail = 0; last = 1;
        end else begin
            e_ready = '0; e_rdv = '0; e_wr = 0; e_rd = 0;
            if (rd_owner >= 0) begin
                if (mm_rv) begin
                    e_rdata = mm_rdata; e_rdv[rd_owner] = 1'b1; rd_owner = -1;
                end else if (TO_EN) begin
                    waited++;
                    if (waited == TO) begin
                        e_rdata = TIMEOUT_PAT; e_rdv[rd_owner] = 1'b1; rd_owner = -1; hit = 1;
                    end
                end
            end else if (wr_tail > 0) begin
                wr_tail = 0;
            end else begin
                p = r_wr | r_rd;
                if (p != 0) begin
                    w = (p == 2'b11) ? 1 - last : (p[0] ? 0 : 1);
                    last = w;
                    e_addr = r_addr[w]; e_wd = r_wd[w]; e_ready[w] = 1'b1;
                    if (r_wr[w]) begin e_wr = 1; wr_tail = 1; end
                    else begin e_rd = 1; rd_owner = w; waited = 0; end
                end
            end
            if (hit) e_terr = 1;
            else if (tclr) e_terr = 0;
        end
    end

    always @(negedge clk) if (m_live) begin
        chk("m_ready", o_ready, e_ready);
        chk("m_wr_en", mm_wr_en, e_wr);
        chk("m_rd_en", mm_rd_en, e_rd);
        chk("m_addr", mm_addr, e_addr);
        chk("m_wdata", mm_wdata, e_wd);
        chk("m_rdv", o_rdv, e_rdv);
        chk("m_rdata0", o_rd0, e_rdata);
        chk("m_rdata1", o_rd1, e_rdata);
        chk("m_terr", terr, e_terr);
    end

    task automatic step(); @(negedge clk); #2; endtask

    task automatic chk_zero(string tag);
        chk({tag, "_ctl"}, {mm_wr_en, mm_rd_en, o_ready, o_rdv, terr}, 0);
        chk({tag, "_addr"}, mm_addr, 0);
        chk({tag, "_wdata"}, mm_wdata, 0);
        chk({tag, "_rd0"}, o_rd0, 0);
        chk({tag, "_rd1"}, o_rd1, 0);
    endtask

    task automatic do_reset();
        rst_n = 0; step(); rst_n = 1; step();
    endtask

    initial begin
        logic [1:0] seen;
        int n_str, alt_bad, nxt;
        repeat (3) step();
        chk_zero("reset");
        rst_n = 1; step();

        // Single write from rq0.
        r_wr[0] = 1; r_addr[0] = 17'h00010; r_wd[0] = 64'h1234; step();
        chk("w_wr_en", mm_wr_en, 1); chk("w_addr", mm_addr, 17'h00010);
        chk("w_wdata", mm_wdata, 64'h1234); chk("w_ready", o_ready, 2'b01);
        r_wr[0] = 0; step();
        chk("w_wr_en_off", {mm_wr_en, o_ready}, 0);
        step();
        r_wr[1] = 1; r_addr[1] = 17'h1FFFF; r_wd[1] = 64'hFFFF_0000_1111_2222; step();
        chk("w_idle_ready", o_ready, 2'b10); chk("w_idle_addr", mm_addr, 17'h1FFFF);
        r_wr[1] = 0; step();

        // rq1 read, data returned three cycles later.
        r_rd[1] = 1; r_addr[1] = 17'h10203; step();
        chk("r1_rd_en", mm_rd_en, 1); chk("r1_ready", o_ready, 2'b10);
        r_rd[1] = 0; step(); step(); step();
        chk("r1_wait_rdv", o_rdv, 0);
        mm_rdata = 64'hA5; mm_rv = 1; step(); mm_rv = 0;
        chk("r1_rdv", o_rdv, 2'b10); chk("r1_data", o_rd1, 64'hA5);
        step(); chk("r1_rdv_off", o_rdv, 0);

        // Simultaneous reads after reset: rq0 first, rq1 only after rq0's data.
        do_reset();
        r_rd = 2'b11; r_addr[0] = 17'h00100; r_addr[1] = 17'h00200; step();
        chk("rr_first", o_ready, 2'b01); chk("rr_addr0", mm_addr, 17'h00100);
        r_rd[0] = 0; step(); chk("rr_hold", o_ready, 0); step();
        mm_rdata = 64'h77; mm_rv = 1; step(); mm_rv = 0;
        chk("rr_rdv0", o_rdv, 2'b01);
        step(); chk("rr_second", o_ready, 2'b10); chk("rr_addr1", mm_addr, 17'h00200);
        r_rd[1] = 0; step();
        mm_rdata = 64'h88; mm_rv = 1; step(); mm_rv = 0;
        chk("rr_rdv1", o_rdv, 2'b10); chk("rr_data1", o_rd1, 64'h88);
        step();

        // Read with no return: timeout pattern, or indefinite wait when disabled.
        r_rd[0] = 1; r_addr[0] = 17'h00042; step();
        chk("to_rd_en", mm_rd_en, 1);
        r_rd[0] = 0; seen = 0;
`ifdef MM_ARB_TIMEOUT_EN
        repeat (TO - 1) begin step(); seen |= o_rdv; end
        chk("to_early", seen, 0);
        step();
        chk("to_rdv", o_rdv, 2'b01); chk("to_data", o_rd0, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("to_err", terr, 1);
        step(); chk("to_sticky", terr, 1);
        tclr = 1; step(); tclr = 0;
        chk("to_clr", terr, 0);
`else
        repeat (40) begin step(); seen |= o_rdv; end
        chk("nto_wait", seen, 0); chk("nto_err", terr, 0);
        mm_rdata = 64'h5A5A; mm_rv = 1; step(); mm_rv = 0;
        chk("nto_rdv", o_rdv, 2'b01); chk("nto_data", o_rd0, 64'h5A5A);
`endif
        step();

        // Continuous writes from both for 20 cycles.
        do_reset();
        r_wr = 2'b11; r_addr[0] = 17'h0AAAA; r_addr[1] = 17'h15555;
        n_str = 0; alt_bad = 0; nxt = 0;
        repeat (20) begin
            step();
            if (mm_wr_en) begin
                n_str++;
                if (o_ready != (nxt ? 2'b10 : 2'b01)) alt_bad++;
                nxt = 1 - nxt;
            end
        end
        r_wr = 0;
        chk("bb_strobes", n_str, 10); chk("bb_alternate", alt_bad, 0);
        step(); step();

        // Reset in the middle of a read, then a late return.
        r_rd[0] = 1; r_addr[0] = 17'h00333; step();
        chk("rst_rd_en", mm_rd_en, 1);
        r_rd[0] = 0; step();
        rst_n = 0; #1; chk_zero("rst_mid");
        step(); rst_n = 1; mm_rdata = 64'hBAD; mm_rv = 1;
        step(); mm_rv = 0; seen = o_rdv;
        step(); seen |= o_rdv;
        chk("rst_late_rdv", seen, 0);
        r_wr[1] = 1; r_addr[1] = 17'h00444; r_wd[1] = 64'h99; step();
        chk("rst_next_ready", o_ready, 2'b10); chk("rst_next_wr", mm_wr_en, 1);
        r_wr[1] = 0; step();

        // Randomized traffic; requesters hold each request until its ready pulse.
        repeat (4000) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (o_ready[i] || !(r_wr[i] | r_rd[i])) begin
                    if ($urandom_range(9) < 4) begin
                        int k;
                        k = $urandom_range(2);
                        r_wr[i] = (k != 1); r_rd[i] = (k != 0);
                        r_addr[i] = 17'($urandom); r_wd[i] = {$urandom, $urandom};
                    end else begin
                        r_wr[i] = 0; r_rd[i] = 0;
                    end
                end
            end
            mm_rv = ($urandom_range(99) < 12);
            mm_rdata = {$urandom, $urandom};
            tclr = ($urandom_range(99) < 4);
            rst_n = !($urandom_range(999) < 3);
        end
        r_wr = 0; r_rd = 0; mm_rv = 0; tclr = 0; rst_n = 1;
        repeat (5) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
